bus_arbiter_mux: RTL and testbench
==================================

Name: bus_arbiter_mux

Overview:
- Parametrised, registered successor to the datapath's 32-source encoder/mux bus.
- Selects one of NSRC WIDTH-bit sources onto the shared bus in one of two modes:
  - Direct mode: the control unit supplies one-hot drive enables.
  - Arbitrated mode: sources raise requests and a round-robin arbiter with bounded hold grants bus ownership.
- Also flags multi-driver conflicts and reports the winning source index.

Parameters:
- WIDTH, 32, bit width of each source and of the bus.
- NSRC, 32, number of sources (≥2).
- SEL_W, $clog2(NSRC), derived width of the source index; not overridden.
- MAX_HOLD, 4, maximum consecutive cycles one owner keeps the grant in arbitrated mode (≥1).
- REG_OUT, 1, 1 = bus_out/bus_valid registered (1-cycle latency); 0 = combinational from current select/grant.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-high reset.
- mode  in  1  0 = direct select, 1 = arbitrated.
- bus_in  in  NSRC*WIDTH  packed sources; source i at bits [i*WIDTH +: WIDTH].
- sel_onehot  in  NSRC  direct-mode drive enables.
- req  in  NSRC  arbitrated-mode requests; level-sensitive.
- conflict_clr  in  1  clears the sticky conflict flag.
- bus_out  out  WIDTH  bus value.
- bus_valid  out  1  bus_out carries a selected source.
- grant  out  NSRC  one-hot registered grant; arbitrated mode only, 0 in direct mode.
- src_id  out  SEL_W  index of the source on bus_out.
- conflict  out  1  sticky multi-driver error.

Behaviour:
- Reset (clr=1, asynchronous) forces:
  - bus_out=0, bus_valid=0, grant=0, src_id=0, conflict=0.
  - Round-robin pointer ptr=0, hold counter cnt=0, state IDLE.
- Direct mode (mode=0):
  - Lowest set index of sel_onehot wins (priority encode).
  - REG_OUT=1: at each edge, bus_out<=bus_in[win], src_id<=win, bus_valid<=|sel_onehot.
  - No bit set: bus_out<=0, bus_valid<=0, src_id holds.
  - Two or more bits set: conflict set at the next edge.
- Arbitrated FSM (mode=1), states IDLE and OWN:
  - IDLE: if any req, pick the first set req scanning upward from ptr with wrap-around (index NSRC-1 wraps to 0). At the edge: grant<=onehot(w), owner<=w, cnt<=1, state→OWN. No req: stay in IDLE, grant=0.
  - OWN, keep: req[owner]=1 and cnt<MAX_HOLD → grant held, cnt<=cnt+1.
  - OWN, release: req[owner]=0 or cnt==MAX_HOLD → release, ptr<=owner+1 (mod NSRC).
    - Other requests pending: re-arbitrate from owner+1 in the same cycle and grant the new owner at that edge (no idle bubble), cnt<=1.
    - Nothing pending: grant<=0, state→IDLE.
    - Sole requester at MAX_HOLD: re-grants to itself with cnt<=1; the grant stays continuously high.
- Bus output in arbitrated mode:
  - REG_OUT=1: bus_out<=bus_in[owner], src_id<=owner, bus_valid<=(state==OWN), sampled on the edge after grant is visible. Latency: req at edge t → grant visible after t → data/valid visible after t+1.
  - REG_OUT=0: bus_out/bus_valid/src_id are combinational from the current grant; latency 0 after grant.
- conflict in arbitrated mode is never set by the arbiter; sel_onehot is ignored.
- Mode change mid-ownership: the next edge forces grant=0, state IDLE, cnt=0, ptr unchanged; the new mode's selection applies from that edge.
- conflict handling:
  - Sticky until conflict_clr=1 at an edge.
  - A new conflict in the same cycle as conflict_clr wins (stays 1).
- Reset mid-grant: all state clears immediately, with no wait for the edge.

Test Plan (WIDTH=32, NSRC=32, MAX_HOLD=4, REG_OUT=1; source i drives 0xA000_0000+i):
- Reset: assert clr asynchronously mid-cycle while owner=5 → grant, bus_out, bus_valid, conflict read 0 immediately; after release, the first req[9] grants 9 (ptr reset to 0).
- Direct select: mode=0, sel_onehot=1<<21 → after one edge bus_out=0xA000_0015, src_id=21, bus_valid=1, conflict=0. Then sel_onehot=0 → bus_valid=0, bus_out=0.
- Conflict: sel_onehot=(1<<3)|(1<<7) → bus_out=0xA000_0003, conflict=1.
  - conflict_clr=1 with sel_onehot still conflicting → conflict stays 1.
  - Legal select, then conflict_clr → conflict=0.
- Round-robin: mode=1, req={0,4,31} held → grants 0 (4 cycles), 4 (4 cycles), 31 (4 cycles), then 0; no idle cycle between owners; bus_out follows one cycle behind grant.
- Hold and release: only req[10] held 10 cycles → grant[10] continuous; src_id=10. Drop req[10] at cycle 2 of ownership with req[2] pending → grant moves to 2 at the next edge.
- Mode switch: owner=12 in mode=1, set mode=0 with sel_onehot=1<<6 → next edge grant=0; the following edge bus_out=0xA000_0006, src_id=6.

Source files
------------

// File: rtl/bus_arbiter_mux.sv
// bus_arbiter_mux: shared-bus source selector.
// Direct mode drives the bus from one-hot enables supplied by the control unit.
// Arbitrated mode hands the bus out round-robin, with a bounded hold time per owner.
// Also reports the winning source index and a sticky multi-driver conflict flag.
module bus_arbiter_mux #(
    parameter int WIDTH    = 32,
    parameter int NSRC     = 32,
    parameter int SEL_W    = $clog2(NSRC),
    parameter int MAX_HOLD = 4,
    parameter int REG_OUT  = 1
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    mode,
    input  logic [NSRC*WIDTH-1:0]   bus_in,
    input  logic [NSRC-1:0]         sel_onehot,
    input  logic [NSRC-1:0]         req,
    input  logic                    conflict_clr,
    output logic [WIDTH-1:0]        bus_out,
    output logic                    bus_valid,
    output logic [NSRC-1:0]         grant,
    output logic [SEL_W-1:0]        src_id,
    output logic                    conflict
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   owner, owner_nxt;
    logic [SEL_W-1:0]   ptr, ptr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [NSRC-1:0]    grant_nxt;

    logic [WIDTH-1:0]   srcs [NSRC];

    logic [SEL_W-1:0]   dir_win;
    logic               dir_any;
    logic               dir_multi;

    logic [SEL_W-1:0]   owner_inc;
    logic [SEL_W-1:0]   arb_start;
    logic [SEL_W-1:0]   arb_win;
    logic               arb_hit;

    logic [WIDTH-1:0]   sel_bus;
    logic               sel_valid;
    logic [SEL_W-1:0]   sel_src;

    logic [WIDTH-1:0]   bus_q;
    logic               valid_q;
    logic [SEL_W-1:0]   src_q;
    logic               conflict_nxt;

    // Index of the source found 'off' positions above 'base', wrapping past NSRC-1 to 0.
    function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NSRC) begin
            s = s - NSRC;
        end
        return SEL_W'(s);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_unpack
            assign srcs[gi] = bus_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign dir_any   = |sel_onehot;
    assign dir_multi = |(sel_onehot & (sel_onehot - NSRC'(1)));
    assign owner_inc = (owner == SEL_W'(NSRC - 1)) ? '0 : owner + SEL_W'(1);

    // Direct mode: the lowest-numbered enabled driver wins.
    always_comb begin
        dir_win = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (sel_onehot[i]) begin
                dir_win = SEL_W'(i);
            end
        end
    end

    // Round-robin scan: an idle arbiter starts at ptr, a releasing owner starts just past itself.
    always_comb begin
        arb_start = (state == OWN) ? owner_inc : ptr;
        arb_hit   = 1'b0;
        arb_win   = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (req[wrap_idx(arb_start, k)]) begin
                arb_hit = 1'b1;
                arb_win = wrap_idx(arb_start, k);
            end
        end
    end

    // Arbiter next state: grant, keep for up to MAX_HOLD cycles, hand over without a bubble.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        grant_nxt = grant;
        if (!mode) begin
            state_nxt = IDLE;
            grant_nxt = '0;
            cnt_nxt   = '0;
        end else if (state == IDLE) begin
            if (arb_hit) begin
                state_nxt = OWN;
                owner_nxt = arb_win;
                grant_nxt = NSRC'(1) << arb_win;
                cnt_nxt   = CNT_W'(1);
            end else begin
                grant_nxt = '0;
                cnt_nxt   = '0;
            end
        end else begin
            if (req[owner] && (cnt < CNT_W'(MAX_HOLD))) begin
                cnt_nxt = cnt + CNT_W'(1);
            end else begin
                ptr_nxt = owner_inc;
                if (arb_hit) begin
                    owner_nxt = arb_win;
                    grant_nxt = NSRC'(1) << arb_win;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    cnt_nxt   = '0;
                end
            end
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            cnt   <= '0;
            grant <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            grant <= grant_nxt;
        end
    end

    // Bus value for the current selection; an idle bus reads 0 and src_id keeps its last value.
    always_comb begin
        sel_bus   = '0;
        sel_valid = 1'b0;
        sel_src   = src_q;
        if (!mode) begin
            if (dir_any) begin
                sel_bus   = srcs[dir_win];
                sel_valid = 1'b1;
                sel_src   = dir_win;
            end
        end else if (state == OWN) begin
            sel_bus   = srcs[owner];
            sel_valid = 1'b1;
            sel_src   = owner;
        end
    end

    // Conflicts only arise in direct mode; a fresh conflict beats a simultaneous clear.
    always_comb begin
        conflict_nxt = conflict;
        if (!mode && dir_multi) begin
            conflict_nxt = 1'b1;
        end else if (conflict_clr) begin
            conflict_nxt = 1'b0;
        end
    end

    // Output and conflict registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            bus_q    <= '0;
            valid_q  <= 1'b0;
            src_q    <= '0;
            conflict <= 1'b0;
        end else begin
            bus_q    <= sel_bus;
            valid_q  <= sel_valid;
            src_q    <= sel_src;
            conflict <= conflict_nxt;
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            assign bus_out   = bus_q;
            assign bus_valid = valid_q;
            assign src_id    = src_q;
        end else begin : g_comb
            assign bus_out   = sel_bus;
            assign bus_valid = sel_valid;
            assign src_id    = sel_src;
        end
    endgenerate

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// tb_bus_arbiter_mux: directed and random stimulus for bus_arbiter_mux.
// Expected values come from a cycle-level behavioural model of the selection rules.
module tb_bus_arbiter_mux;

    localparam int WIDTH = 32;
    localparam int NSRC  = 32;

    logic                  clk;
    logic                  clr;
    logic                  mode;
    logic [NSRC*WIDTH-1:0] bus_in;
    logic [NSRC-1:0]       sel_onehot;
    logic [NSRC-1:0]       req;
    logic                  conflict_clr;
    logic [WIDTH-1:0]      bus_out;
    logic                  bus_valid;
    logic [NSRC-1:0]       grant;
    logic [4:0]            src_id;
    logic                  conflict;

    int n_assert;
    int n_fail;

    // Model state: current owner (-1 when nobody holds the bus), cycles held, scan start.
    int          m_owner;
    int          m_ten;
    int          m_ptr;
    logic [31:0] e_bus;
    logic        e_valid;
    int          e_src;
    logic        e_conf;
    logic        e_bus_chk;

    bus_arbiter_mux #(
        .WIDTH(WIDTH),
        .NSRC(NSRC),
        .MAX_HOLD(4),
        .REG_OUT(1)
    ) dut (
        .clk(clk),
        .clr(clr),
        .mode(mode),
        .bus_in(bus_in),
        .sel_onehot(sel_onehot),
        .req(req),
        .conflict_clr(conflict_clr),
        .bus_out(bus_out),
        .bus_valid(bus_valid),
        .grant(grant),
        .src_id(src_id),
        .conflict(conflict)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            assign bus_in[gi*WIDTH +: WIDTH] = 32'hA000_0000 + gi;
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] src_data(input int i);
        return 32'hA000_0000 + i;
    endfunction

    function automatic int lowest_set(input logic [31:0] v);
        for (int i = 0; i < 32; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic int first_from(input logic [31:0] r, input int start);
        int j;
        for (int k = 0; k < 32; k++) begin
            j = (start + k) % 32;
            if (r[j[4:0]]) return j;
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_grant();
        if (m_owner < 0) return 32'h0;
        return 32'h1 << m_owner;
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_ten     = 0;
        m_ptr     = 0;
        e_bus     = 32'h0;
        e_valid   = 1'b0;
        e_src     = 0;
        e_conf    = 1'b0;
        e_bus_chk = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic m, input logic [31:0] s, input logic [31:0] r, input logic cc);
        mode         = m;
        sel_onehot   = s;
        req          = r;
        conflict_clr = cc;
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, "_grant"},    grant,             exp_grant());
        chk({tag, "_valid"},    {31'h0, bus_valid}, {31'h0, e_valid});
        chk({tag, "_src"},      {27'h0, src_id},    32'(e_src));
        chk({tag, "_conflict"}, {31'h0, conflict},  {31'h0, e_conf});
        if (e_bus_chk) begin
            chk({tag, "_bus"}, bus_out, e_bus);
        end
    endtask

    // One rising edge: predict from the pre-edge inputs and model state, then let the DUT clock.
    task automatic tick();
        int w;
        if (!mode) begin
            w = lowest_set(sel_onehot);
            if (w >= 0) begin
                e_valid = 1'b1;
                e_bus   = src_data(w);
                e_src   = w;
            end else begin
                e_valid = 1'b0;
                e_bus   = 32'h0;
            end
            e_bus_chk = 1'b1;
            if ($countones(sel_onehot) >= 2) e_conf = 1'b1;
            else if (conflict_clr)           e_conf = 1'b0;
            m_owner = -1;
            m_ten   = 0;
        end else begin
            if (m_owner >= 0) begin
                e_valid   = 1'b1;
                e_bus     = src_data(m_owner);
                e_src     = m_owner;
                e_bus_chk = 1'b1;
            end else begin
                e_valid   = 1'b0;
                e_bus_chk = 1'b0;
            end
            if (conflict_clr) e_conf = 1'b0;
            if (m_owner < 0) begin
                w = first_from(req, m_ptr);
                if (w >= 0) begin
                    m_owner = w;
                    m_ten   = 1;
                end
            end else if (req[m_owner] && m_ten < 4) begin
                m_ten++;
            end else begin
                m_ptr   = (m_owner + 1) % 32;
                w       = first_from(req, m_ptr);
                m_owner = w;
                m_ten   = (w >= 0) ? 1 : 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rsel;
        logic [31:0] rreq;
        logic        rmode;
        logic        rcc;

        n_assert = 0;
        n_fail   = 0;
        clr      = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        model_reset();
        #12;
        checkOutput("reset");
        clr = 1'b0;

        $display("[TB] direct select");
        applyStimulus(1'b0, 32'h1 << 21, 32'h0, 1'b0);
        tick();
        checkOutput("direct21");
        chk("direct21_bus_const", bus_out, 32'hA000_0015);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        checkOutput("direct_none");

        $display("[TB] conflict");
        applyStimulus(1'b0, (32'h1 << 3) | (32'h1 << 7), 32'h0, 1'b0);
        tick();
        checkOutput("conflict_set");
        chk("conflict_set_bus_const", bus_out, 32'hA000_0003);
        applyStimulus(1'b0, (32'h1 << 3) | (32'h1 << 7), 32'h0, 1'b1);
        tick();
        checkOutput("conflict_clr_lose");
        chk("conflict_clr_lose_const", {31'h0, conflict}, 32'h1);
        applyStimulus(1'b0, 32'h1 << 7, 32'h0, 1'b0);
        tick();
        checkOutput("conflict_sticky");
        applyStimulus(1'b0, 32'h1 << 7, 32'h0, 1'b1);
        tick();
        checkOutput("conflict_cleared");
        chk("conflict_cleared_const", {31'h0, conflict}, 32'h0);

        $display("[TB] round robin");
        applyStimulus(1'b1, 32'h0, (32'h1 << 0) | (32'h1 << 4) | (32'h1 << 31), 1'b0);
        for (int c = 0; c < 14; c++) begin
            tick();
            checkOutput("rr");
        end

        $display("[TB] hold and release");
        applyStimulus(1'b1, 32'h0, 32'h1 << 10, 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick();
            checkOutput("hold10");
        end
        chk("hold10_src_const", {27'h0, src_id}, 32'd10);
        applyStimulus(1'b1, 32'h0, 32'h0, 1'b0);
        tick();
        checkOutput("idle_a");
        tick();
        checkOutput("idle_b");
        applyStimulus(1'b1, 32'h0, 32'h1 << 10, 1'b0);
        tick();
        checkOutput("own10_c1");
        applyStimulus(1'b1, 32'h0, (32'h1 << 10) | (32'h1 << 2), 1'b0);
        tick();
        checkOutput("own10_c2");
        applyStimulus(1'b1, 32'h0, 32'h1 << 2, 1'b0);
        tick();
        checkOutput("handover2");
        chk("handover2_const", grant, 32'h1 << 2);

        $display("[TB] mode switch");
        applyStimulus(1'b1, 32'h0, 32'h1 << 12, 1'b0);
        tick();
        checkOutput("own12");
        tick();
        checkOutput("own12_data");
        applyStimulus(1'b0, 32'h1 << 6, 32'h1 << 12, 1'b0);
        tick();
        checkOutput("switch_edge1");
        chk("switch_grant_const", grant, 32'h0);
        tick();
        checkOutput("switch_edge2");
        chk("switch_bus_const", bus_out, 32'hA000_0006);

        $display("[TB] async reset mid-grant");
        applyStimulus(1'b0, (32'h1 << 1) | (32'h1 << 2), 32'h0, 1'b0);
        tick();
        checkOutput("pre_reset_conflict");
        applyStimulus(1'b1, 32'h0, 32'h1 << 5, 1'b0);
        tick();
        checkOutput("own5");
        tick();
        checkOutput("own5_data");
        #3;
        clr = 1'b1;
        #1;
        model_reset();
        checkOutput("async_reset");
        #2;
        clr = 1'b0;
        applyStimulus(1'b1, 32'h0, 32'h1 << 9, 1'b0);
        tick();
        checkOutput("post_reset");
        chk("post_reset_grant_const", grant, 32'h1 << 9);

        $display("[TB] random phase");
        for (int c = 0; c < 400; c++) begin
            rmode = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 3))
                0:       rsel = 32'h0;
                1:       rsel = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
                default: rsel = 32'h1 << $urandom_range(0, 31);
            endcase
            case ($urandom_range(0, 4))
                0:       rreq = 32'h0;
                1:       rreq = 32'h1 << $urandom_range(0, 31);
                2:       rreq = $urandom;
                default: rreq = $urandom & $urandom & $urandom;
            endcase
            rcc = ($urandom_range(0, 3) == 0);
            applyStimulus(rmode, rsel, rreq, rcc);
            tick();
            checkOutput("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
